// File: rtl/param_digital_locker.sv
// Keypad locker FSM: PIN verification, attempt limiting with timed lockout, PIN change and a per-slot data vault.
// Optional AUTO_RELOCK_EN macro adds an inactivity timeout that relocks from UNLOCKED.
module param_digital_locker #(
    parameter int PIN_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int SLOTS          = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [PIN_DIGITS*DIGIT_W-1:0] DEFAULT_PIN = 'h4321,
    parameter int RELOCK_CYCLES  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_digit,
    input  logic                          start,
    input  logic                          cancel,
    input  logic                          set_pin,
    input  logic                          store,
    input  logic                          read,
    input  logic [$clog2(SLOTS)-1:0]      slot_sel,
    input  logic                          tamper,
    output logic                          unlocked,
    output logic                          locked,
    output logic                          locked_out,
    output logic                          fail,
    output logic [2:0]                    attempts_left,
    output logic [PIN_DIGITS*DIGIT_W-1:0] data_out,
    output logic                          data_valid
);

    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int LK_W  = $clog2(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIN_DIGITS);
    localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       MAX_W    = 3'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTER, S_VERIFY, S_ERROR, S_LOCKOUT, S_UNLOCKED
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PIN_W-1:0]   r_pin;
    logic [PIN_W-1:0]   r_slot [SLOTS];
    logic [PIN_W-1:0]   r_buf, w_buf_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_wrong, w_wrong_nxt;
    logic [LK_W-1:0]    r_lk_cnt, w_lk_nxt;
    logic [PIN_W-1:0]   r_data_out;
    logic               r_data_valid;
    logic               w_pin_we, w_slot_we, w_rd_en;
    logic               w_full;
    logic [2:0]         w_wrong_inc;
    logic [PIN_W-1:0]   w_buf_shift;

`ifdef AUTO_RELOCK_EN
    localparam int RL_W = $clog2(RELOCK_CYCLES);
    localparam logic [RL_W-1:0] RL_LAST = RL_W'(RELOCK_CYCLES - 1);
    logic [RL_W-1:0] r_idle_cnt, w_idle_nxt;
    logic            w_activity;
    assign w_activity = key_valid | start | set_pin | store | read;
`endif

    // New digit enters at the LSB so the first-entered digit ends up most significant.
    function automatic logic [PIN_W-1:0] f_shift(input logic [PIN_W-1:0] b,
                                                 input logic [DIGIT_W-1:0] d);
        logic [PIN_W-1:0] t;
        t = b << DIGIT_W;
        t[DIGIT_W-1:0] = d;
        return t;
    endfunction

    assign w_full      = (r_cnt == CNT_FULL);
    assign w_wrong_inc = r_wrong + 3'd1;
    assign w_buf_shift = f_shift(r_buf, key_digit);

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_wrong_nxt = r_wrong;
        w_lk_nxt    = '0;
        w_pin_we    = 1'b0;
        w_slot_we   = 1'b0;
        w_rd_en     = 1'b0;
`ifdef AUTO_RELOCK_EN
        w_idle_nxt  = '0;
`endif
        if (tamper) begin
            w_state_nxt = S_LOCKOUT;
            w_wrong_nxt = MAX_W;
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (cancel) begin
                        w_state_nxt = S_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (start) begin
                        w_state_nxt = S_ENTER;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_ENTER: begin
                    if (cancel) begin
                        w_state_nxt = S_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (start) begin
                        w_buf_nxt = '0;
                        w_cnt_nxt = '0;
                    end else if (w_full) begin
                        w_state_nxt = S_VERIFY;
                    end else if (key_valid) begin
                        w_buf_nxt = w_buf_shift;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    w_buf_nxt = '0;
                    w_cnt_nxt = '0;
                    if (cancel) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_buf == r_pin) begin
                        w_state_nxt = S_UNLOCKED;
                        w_wrong_nxt = '0;
                    end else begin
                        w_wrong_nxt = w_wrong_inc;
                        w_state_nxt = (w_wrong_inc == MAX_W) ? S_LOCKOUT : S_ERROR;
                    end
                end
                S_LOCKOUT: begin
                    if (r_lk_cnt == LK_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_wrong_nxt = '0;
                    end else begin
                        w_lk_nxt = r_lk_cnt + LK_W'(1);
                    end
                end
                S_UNLOCKED: begin
                    if (cancel) begin
                        w_state_nxt = S_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (start) begin
                        w_buf_nxt = '0;
                        w_cnt_nxt = '0;
                    end else if (set_pin) begin
                        if (w_full) begin
                            w_pin_we  = 1'b1;
                            w_buf_nxt = '0;
                            w_cnt_nxt = '0;
                        end
                    end else if (store) begin
                        // A simultaneous read is dropped here: store takes the cycle.
                        if (w_full) begin
                            w_slot_we = 1'b1;
                            w_buf_nxt = '0;
                            w_cnt_nxt = '0;
                        end
                    end else if (read) begin
                        w_rd_en = 1'b1;
                    end else if (key_valid) begin
                        w_buf_nxt = w_buf_shift;
                        w_cnt_nxt = w_full ? r_cnt : r_cnt + CNT_W'(1);
                    end
`ifdef AUTO_RELOCK_EN
                    w_idle_nxt = w_activity ? '0 : r_idle_cnt + RL_W'(1);
                    if (!cancel && !w_activity && r_idle_cnt == RL_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_idle_nxt  = '0;
                    end
`endif
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pin        <= DEFAULT_PIN;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_wrong      <= '0;
            r_lk_cnt     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
`ifdef AUTO_RELOCK_EN
            r_idle_cnt   <= '0;
`endif
        end else begin
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wrong      <= w_wrong_nxt;
            r_lk_cnt     <= w_lk_nxt;
            r_data_valid <= w_rd_en;
            if (w_pin_we)  r_pin <= r_buf;
            if (w_slot_we) r_slot[slot_sel] <= r_buf;
            if (w_rd_en)   r_data_out <= r_slot[slot_sel];
`ifdef AUTO_RELOCK_EN
            r_idle_cnt   <= w_idle_nxt;
`endif
        end
    end

    assign unlocked      = (r_state == S_UNLOCKED);
    assign locked        = ~unlocked;
    assign locked_out    = (r_state == S_LOCKOUT);
    assign fail          = (r_state == S_ERROR) || (r_state == S_LOCKOUT);
    assign attempts_left = MAX_W - r_wrong;
    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;

endmodule

// File: doc/param_digital_locker.md
Name: param_digital_locker

Overview:
- Next-generation keypad locker FSM, generalised in PIN length, digit width, number of data slots, attempt limit and lockout duration.
- Verifies an entered PIN and, while unlocked, allows PIN change plus store/read of one data word per slot.
- Adds explicit cancel, a per-slot data vault, an attempts-remaining indication and registered read-data with a valid strobe.
- Sits between the keypad debouncer/decoder and the host status/data interface.

Parameters:
- PIN_DIGITS, 4: digits per PIN and per data word (1..8).
- DIGIT_W, 4: bits per keypad digit.
- SLOTS, 4: number of data slots (power of two, ≥2).
- MAX_ATTEMPTS, 3: consecutive wrong PINs that force lockout (1..7).
- LOCKOUT_CYCLES, 16: clocks spent in LOCKOUT before returning to IDLE (≥2).
- DEFAULT_PIN, 16'h4321: PIN loaded at reset. Width is PIN_DIGITS*DIGIT_W; first-entered digit is the MS digit.
- RELOCK_CYCLES, 64: inactivity timeout, used only with AUTO_RELOCK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  DIGIT_W  digit value
- start  in  1  begin a new entry; clears the entry buffer
- cancel  in  1  abort current entry
- set_pin  in  1  commit buffer as new PIN (UNLOCKED only)
- store  in  1  write buffer to slot_sel (UNLOCKED only)
- read  in  1  request slot_sel contents (UNLOCKED only)
- slot_sel  in  $clog2(SLOTS)  slot index
- tamper  in  1  tamper alarm
- unlocked  out  1  state==UNLOCKED
- locked  out  1  inverse of unlocked
- locked_out  out  1  state==LOCKOUT
- fail  out  1  state==ERROR or LOCKOUT
- attempts_left  out  3  MAX_ATTEMPTS minus wrong-attempt count
- data_out  out  PIN_DIGITS*DIGIT_W  registered read data
- data_valid  out  1  one-cycle strobe accompanying data_out

Behaviour:
- Reset values: state=IDLE, pin=DEFAULT_PIN, all slots=0, buffer=0, digit_cnt=0, wrong_cnt=0, lockout_cnt=0, data_out=0, data_valid=0. Outputs: locked=1, unlocked=0, fail=0, locked_out=0, attempts_left=MAX_ATTEMPTS.
- States and transitions:
  - IDLE: start→ENTER.
  - ENTER: each key_valid shifts key_digit into the buffer LSB and increments digit_cnt. Digits beyond PIN_DIGITS are ignored (counter saturates). Leaves for VERIFY on the cycle after digit_cnt reaches PIN_DIGITS. cancel→IDLE.
  - VERIFY: exactly one cycle.
    - Match→UNLOCKED; wrong_cnt cleared.
    - Mismatch→wrong_cnt+1. If the new count equals MAX_ATTEMPTS→LOCKOUT, else→ERROR.
  - ERROR: start→ENTER. cancel→IDLE.
  - LOCKOUT: lockout_cnt counts from 0. At LOCKOUT_CYCLES-1→IDLE, with wrong_cnt and lockout_cnt cleared. start and cancel are ignored.
  - UNLOCKED: key_valid shifts into the buffer (digit_cnt saturating).
    - set_pin with digit_cnt==PIN_DIGITS loads pin from the buffer, then clears buffer and digit_cnt. With fewer digits it is ignored.
    - store with digit_cnt==PIN_DIGITS writes slot[slot_sel], then clears buffer and digit_cnt.
    - read: data_out=slot[slot_sel] and data_valid=1 on the next cycle.
    - start clears the buffer and stays UNLOCKED.
    - cancel→IDLE (relock); buffer cleared.
- Same-cycle priority: tamper > cancel > start > set_pin > store > read > key_valid.
- tamper from any state→LOCKOUT next cycle, wrong_cnt=MAX_ATTEMPTS, lockout_cnt=0. tamper held keeps lockout_cnt at 0.
- start in IDLE/ERROR clears the buffer and digit_cnt before the first digit; a key_valid in the same cycle is dropped.
- read and store to the same slot in the same cycle: store wins; read is dropped with no data_valid.
- data_out holds its last value between reads.
- Entering IDLE or LOCKOUT clears the buffer.
- Status outputs are decoded from the registered state only (no input-to-output path).

Optional Feature:
- Macro AUTO_RELOCK_EN.
- Defined: an inactivity counter runs in UNLOCKED and is cleared by any key_valid, start, set_pin, store or read. When it reaches RELOCK_CYCLES-1 the FSM goes UNLOCKED→IDLE, buffer cleared.
- Undefined: no counter; UNLOCKED is left only by cancel or tamper.

Test Plan:
- Default params, reset, start, digits 4,3,2,1 → VERIFY one cycle, then unlocked=1, locked=0, attempts_left=3.
- Three entries of 1,1,1,1:
  - after the 1st and 2nd, fail=1 with attempts_left=2 then 1;
  - after the 3rd, locked_out=1 for exactly 16 clocks, then IDLE with attempts_left=3.
- Unlocked, enter 9,8,7,6 + set_pin, relock via cancel → old PIN 4321 fails; 9876 unlocks.
- Unlocked, digits A,B,C,D + store with slot_sel=2, then read slot 2 → next cycle data_out=16'hABCD, data_valid=1 for 1 cycle; read slot 1 → 16'h0000.
- tamper pulse mid-ENTER after 2 digits → LOCKOUT next cycle, attempts_left=0, buffer cleared. rst asserted mid-LOCKOUT → immediate IDLE, PIN=4321, slots=0.
- AUTO_RELOCK_EN, RELOCK_CYCLES=64: unlocked and idle for 64 cycles → locked=1. A key_valid at cycle 60 restarts the timeout.
